lcd_ctrl_gen: RTL
=================

Name: lcd_ctrl_gen

Overview:
- Parametrised image display controller; successor to the fixed 8x8 LCD controller.
- Loads a IMG_W x IMG_H image from the image ROM into an internal pixel buffer.
- Applies a stream of 4-bit commands to a 2x2 operation window, then writes the full image to the image RAM buffer on a write command.
- Sits between the command sequencer and the IROM/IRB macros; handshake uses busy/cmd_valid and a done pulse.

Parameters:
- IMG_W, 8, image width in pixels; power of two, >= 4.
- IMG_H, 8, image height in pixels; power of two, >= 4.
- DATA_W, 8, pixel width in bits.
- AW, $clog2(IMG_W*IMG_H), address width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cmd  input  4  command code.
- cmd_valid  input  1  cmd qualifier.
- IROM_Q  input  DATA_W  ROM read data, valid the cycle after address.
- IROM_EN  output  1  ROM chip enable, active low.
- IROM_A  output  AW  ROM address.
- IRB_RW  output  1  RAM write enable, active low (0 = write).
- IRB_A  output  AW  RAM address.
- IRB_D  output  DATA_W  RAM write data.
- busy  output  1  high = command not accepted.
- done  output  1  one-cycle pulse after the last IRB write.

Behaviour:
- Reset values: IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0.
- Reset also sets the window point (px,py) to (IMG_W/2, IMG_H/2).
- States: LOAD, IDLE, EXEC, WRITE.
- Reset has priority in any state, including mid-LOAD and mid-WRITE; the FSM returns to LOAD on the next cycle.
- LOAD:
  - IROM_EN=0 and IROM_A = 0..N-1 over N consecutive cycles, where N = IMG_W*IMG_H.
  - Pixel k is captured from IROM_Q one cycle after address k.
  - After the last capture: IROM_EN=1, busy=0, go to IDLE.
  - Total from reset release to busy low: N+2 cycles.
- Accept rule: a command is accepted on a rising edge with cmd_valid=1 and busy=0. busy goes high the next cycle. cmd_valid while busy=1 is ignored.
- EXEC: one cycle for commands 1..11, then busy=0 and return to IDLE. Command throughput is one per 2 cycles.
- Window definition: pixels (px-1,py-1)=TL, (px,py-1)=TR, (px-1,py)=BL, (px,py)=BR. Pixel index = y*IMG_W + x.
- Commands:
  - 0 write: enter WRITE.
  - 1 up: py-1. 2 down: py+1. 3 left: px-1. 4 right: px+1.
  - 5 max: all four window pixels = maximum of the four.
  - 6 min: all four window pixels = minimum of the four.
  - 7 average: all four = floor(sum/4). The sum is computed in DATA_W+2 bits, so no overflow.
  - 8 rotate CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 9 rotate CW: TL<=BL, BL<=BR, BR<=TR, TR<=TL.
  - 10 mirror X: swap the top row with the bottom row.
  - 11 mirror Y: swap the left column with the right column.
  - 12..15: no operation; still uses EXEC for one cycle.
- Shift bounds: px in [1, IMG_W-1], py in [1, IMG_H-1]. Default behaviour is to clamp: a shift past a bound leaves the coordinate unchanged.
- WRITE:
  - IRB_RW=0 and IRB_A = 0..N-1 with IRB_D = pixel[IRB_A], over N consecutive cycles; all three are registered outputs.
  - The cycle after the last write: IRB_RW=1, done=1 for exactly one cycle, busy=0, go to IDLE.
  - Further commands after done are legal.

Optional Feature:
- Macro: LCD_CTRL_GEN_WRAP_EN.
- Defined: shifts wrap inside the legal range instead of clamping.
  - up from py=1 gives py=IMG_H-1; down from py=IMG_H-1 gives py=1.
  - left/right wrap px the same way between 1 and IMG_W-1.
- Undefined: clamp, as in Behaviour.

Decomposition:
- Package lcd_ctrl_gen_pkg holds:
  - the cmd code constants (CMD_WRITE ... CMD_MIRY);
  - the state enum (LOAD/IDLE/EXEC/WRITE);
  - a helper function for the index computation.
- One sub-module, lcd_win_alu: combinational; takes 4 window pixels plus the command and returns 4 new pixels.
  - Covers max, min, average, rotate and mirror.
  - Parametrised by DATA_W.

Test Plan:
- IROM[i]=i, 8x8, no commands except write -> busy low at cycle 66 after reset release; IRB[i]=i for all 64; done pulses once, 65 cycles after acceptance.
- 5x up from (4,4), then average -> py clamps at 1; rows 0..1, cols 3..4 = {3,4,11,12} all become 7; other pixels unchanged.
- average at (4,4) with IROM[i]=i -> pixels 27,28,35,36 all become 31.
- rotate CW then rotate CCW at (4,4) -> image restored. A single mirror Y -> pixel 27 = 28 and 28 = 27.
- cmd_valid held high during write with cmd=3 -> ignored until busy drops; px changes only after done. reset asserted at write cycle 20 -> IRB_RW=1 next cycle, then reload from IROM.
- LCD_CTRL_GEN_WRAP_EN defined, 4x left from px=4 -> px sequence 3,2,1,7; undefined -> 3,2,1,1.

Source files
------------

// File: rtl/lcd_ctrl_gen_pkg.sv
// lcd_ctrl_gen_pkg
// Shared definitions for the parametrised LCD image controller:
//   - 4-bit command codes accepted on the cmd port
//   - controller state encoding
//   - pix_index(): linear pixel index from (x, y) for a given image width
package lcd_ctrl_gen_pkg;

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_MAX    = 4'd5;
  localparam logic [3:0] CMD_MIN    = 4'd6;
  localparam logic [3:0] CMD_AVG    = 4'd7;
  localparam logic [3:0] CMD_ROTCCW = 4'd8;
  localparam logic [3:0] CMD_ROTCW  = 4'd9;
  localparam logic [3:0] CMD_MIRX   = 4'd10;
  localparam logic [3:0] CMD_MIRY   = 4'd11;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Row-major pixel index; callers truncate to their address width.
  function automatic int unsigned pix_index(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu
// Combinational operator for the 2x2 operation window.
// Ports:
//   cmd                     command code (only 5..11 modify pixels)
//   tl, tr, bl, br          current window pixels
//   new_tl .. new_br        window pixels after the command
// Commands other than max/min/average/rotate/mirror pass the pixels through.
module lcd_win_alu
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] tl,
  input  logic [DATA_W-1:0] tr,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] br,
  output logic [DATA_W-1:0] new_tl,
  output logic [DATA_W-1:0] new_tr,
  output logic [DATA_W-1:0] new_bl,
  output logic [DATA_W-1:0] new_br
);

  logic [DATA_W-1:0] max_top, max_bot, max_all;
  logic [DATA_W-1:0] min_top, min_bot, min_all;
  logic [DATA_W+1:0] sum;

  // Reduction trees for max/min, a two-bit-wider sum so the average of
  // four full-scale pixels cannot overflow, then the per-command mapping.
  always_comb begin
    max_top = (tl > tr) ? tl : tr;
    max_bot = (bl > br) ? bl : br;
    max_all = (max_top > max_bot) ? max_top : max_bot;
    min_top = (tl < tr) ? tl : tr;
    min_bot = (bl < br) ? bl : br;
    min_all = (min_top < min_bot) ? min_top : min_bot;
    sum     = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};

    new_tl = tl;
    new_tr = tr;
    new_bl = bl;
    new_br = br;
    case (cmd)
      CMD_MAX: begin
        new_tl = max_all; new_tr = max_all; new_bl = max_all; new_br = max_all;
      end
      CMD_MIN: begin
        new_tl = min_all; new_tr = min_all; new_bl = min_all; new_br = min_all;
      end
      CMD_AVG: begin
        new_tl = sum[DATA_W+1:2];
        new_tr = sum[DATA_W+1:2];
        new_bl = sum[DATA_W+1:2];
        new_br = sum[DATA_W+1:2];
      end
      CMD_ROTCCW: begin
        new_tl = tr; new_tr = br; new_br = bl; new_bl = tl;
      end
      CMD_ROTCW: begin
        new_tl = bl; new_bl = br; new_br = tr; new_tr = tl;
      end
      CMD_MIRX: begin
        new_tl = bl; new_bl = tl; new_tr = br; new_br = tr;
      end
      CMD_MIRY: begin
        new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// lcd_ctrl_gen
// Parametrised image display controller. Loads IMG_W x IMG_H pixels from the
// image ROM, applies window commands, and dumps the image to the IRB RAM.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmd, cmd_valid      command code and qualifier (accepted when busy=0)
//   IROM_Q              ROM data, valid the cycle after the address
//   IROM_EN, IROM_A     ROM enable (active low) and address
//   IRB_RW, IRB_A, IRB_D RAM write enable (0 = write), address, data
//   busy                high while a command cannot be accepted
//   done                one-cycle pulse after the last RAM write
// Build option: define LCD_CTRL_GEN_WRAP_EN to make window shifts wrap
// within the legal coordinate range instead of clamping.
module lcd_ctrl_gen
  import lcd_ctrl_gen_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_EN,
  output logic [AW-1:0]     IROM_A,
  output logic              IRB_RW,
  output logic [AW-1:0]     IRB_A,
  output logic [DATA_W-1:0] IRB_D,
  output logic              busy,
  output logic              done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = AW + 1;

`ifdef LCD_CTRL_GEN_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XW-1:0]     px, px_nxt, px_m1;
  logic [YW-1:0]     py, py_nxt, py_m1;
  logic [3:0]        cmd_r;
  logic [DATA_W-1:0] pix [N];

  logic [AW-1:0]     idx_tl, idx_tr, idx_bl, idx_br;
  logic [DATA_W-1:0] new_tl, new_tr, new_bl, new_br;

  // Window addresses: (px,py) is the bottom-right corner of the 2x2 window.
  always_comb begin
    px_m1  = px - 1'b1;
    py_m1  = py - 1'b1;
    idx_tl = AW'(pix_index(32'(px_m1), 32'(py_m1), IMG_W));
    idx_tr = AW'(pix_index(32'(px),    32'(py_m1), IMG_W));
    idx_bl = AW'(pix_index(32'(px_m1), 32'(py),    IMG_W));
    idx_br = AW'(pix_index(32'(px),    32'(py),    IMG_W));
  end

  // Next window position for shift commands; at a bound the coordinate
  // either stays put or wraps to the opposite legal edge.
  always_comb begin
    px_nxt = px;
    py_nxt = py;
    case (cmd_r)
      CMD_UP:    py_nxt = (py > YW'(1))         ? py - 1'b1 : (WRAP ? YW'(IMG_H - 1) : py);
      CMD_DOWN:  py_nxt = (py < YW'(IMG_H - 1)) ? py + 1'b1 : (WRAP ? YW'(1) : py);
      CMD_LEFT:  px_nxt = (px > XW'(1))         ? px - 1'b1 : (WRAP ? XW'(IMG_W - 1) : px);
      CMD_RIGHT: px_nxt = (px < XW'(IMG_W - 1)) ? px + 1'b1 : (WRAP ? XW'(1) : px);
      default: ;
    endcase
  end

  lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
    .cmd    (cmd_r),
    .tl     (pix[idx_tl]),
    .tr     (pix[idx_tr]),
    .bl     (pix[idx_bl]),
    .br     (pix[idx_br]),
    .new_tl (new_tl),
    .new_tr (new_tr),
    .new_bl (new_bl),
    .new_br (new_br)
  );

  // Controller FSM. cnt sequences both the ROM load and the RAM dump.
  // During LOAD the capture trails the address by two edges (address
  // register, then ROM latency), so the low AW bits of cnt-2 wrap
  // correctly to N-2 and N-1 for the final two captures.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD;
      cnt     <= '0;
      px      <= XW'(IMG_W / 2);
      py      <= YW'(IMG_H / 2);
      cmd_r   <= '0;
      IROM_EN <= 1'b1;
      IROM_A  <= '0;
      IRB_RW  <= 1'b1;
      IRB_A   <= '0;
      IRB_D   <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (cnt < CW'(N)) begin
            IROM_EN <= 1'b0;
            IROM_A  <= cnt[AW-1:0];
          end else begin
            IROM_EN <= 1'b1;
          end
          if (cnt >= CW'(2))
            pix[cnt[AW-1:0] - AW'(2)] <= IROM_Q;
          if (cnt == CW'(N + 1)) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            busy  <= 1'b1;
            cmd_r <= cmd;
            cnt   <= '0;
            state <= (cmd == CMD_WRITE) ? WRITE : EXEC;
          end
        end
        EXEC: begin
          px <= px_nxt;
          py <= py_nxt;
          if (cmd_r >= CMD_MAX && cmd_r <= CMD_MIRY) begin
            pix[idx_tl] <= new_tl;
            pix[idx_tr] <= new_tr;
            pix[idx_bl] <= new_bl;
            pix[idx_br] <= new_br;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        WRITE: begin
          if (cnt < CW'(N)) begin
            IRB_RW <= 1'b0;
            IRB_A  <= cnt[AW-1:0];
            IRB_D  <= pix[cnt[AW-1:0]];
            cnt    <= cnt + 1'b1;
          end else begin
            IRB_RW <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
